baccarat_sequencer: RTL

Parametrised successor to the single-round Punto Banco controller. It sequences card loads for one round per `start` request, applies the full player and banker third-card rules, and latches the result lights. It also keeps saturating win tallies and a wrapping round counter for the scoreboard. It sits between the card-dealing/scoring datapath (which supplies `pscore`, `dscore`, `pcard3`) and the display logic.

---
 rtl/baccarat_pkg.sv | 14 +
 rtl/sat_counter.sv | 16 +
 rtl/baccarat_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared state encoding, score type and banker third-card rule
package baccarat_pkg;
  typedef enum logic [3:0] {IDLE, P1, D1, P2, D2, DECIDE, P3, BDEC, D3, RESULT} bac_state_t;
  typedef logic [3:0] score_t;
  localparam score_t NATURAL_MIN = 4'd8;
  // Banker's third-card tableau, used only after the player has drawn.
  function automatic logic banker_draws(score_t dscore, score_t pcard3);
    return (dscore <= 4'd2) ||
           (dscore == 4'd3 && pcard3 != 4'd8) ||
           (dscore == 4'd4 && pcard3 >= 4'd2 && pcard3 <= 4'd7) ||
           (dscore == 4'd5 && pcard3 >= 4'd4 && pcard3 <= 4'd7) ||
           (dscore == 4'd6 && pcard3 >= 4'd6 && pcard3 <= 4'd7);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; clr beats inc
// Ports: clk, rst (async, active-high), inc, clr, count.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/baccarat_sequencer.sv
// baccarat_sequencer: Punto Banco round sequencer with result lights, win tallies and round counter
// Ports: slow_clock/reset (async, active-high); start, clear_tally; pscore, dscore, pcard3 from the
// datapath; load_* card strobes; player/dealer lights; busy, round_done; tallies and round_count.
// Build option: BACCARAT_TIE_TALLY_EN implements the ties counter, otherwise ties is tied to 0.
module baccarat_sequencer
  import baccarat_pkg::*;
#(
  parameter int TALLY_W = 8,
  parameter int ROUND_W = 8
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               start,
  input  logic               clear_tally,
  input  score_t             pscore,
  input  score_t             dscore,
  input  score_t             pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               round_done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties,
  output logic [ROUND_W-1:0] round_count
);
  bac_state_t state, next;
  logic is_result;
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? P1 : IDLE;
      P1:      next = D1;
      D1:      next = P2;
      P2:      next = D2;
      D2:      next = DECIDE;
      // Natural ends the round; else player draws on 0..5; else banker draws on 0..5.
      DECIDE:  next = (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) ? RESULT :
                      (pscore <= 4'd5) ? P3 :
                      (dscore <= 4'd5) ? D3 : RESULT;
      P3:      next = BDEC;
      BDEC:    next = banker_draws(dscore, pcard3) ? D3 : RESULT;
      D3:      next = RESULT;
      RESULT:  next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign load_pcard1 = state == P1;
  assign load_dcard1 = state == D1;
  assign load_pcard2 = state == P2;
  assign load_dcard2 = state == D2;
  assign load_pcard3 = state == P3;
  assign load_dcard3 = state == D3;
  assign busy        = state != IDLE;
  assign is_result   = state == RESULT;
  assign round_done  = is_result;
  // Lights capture the outcome as RESULT is left and stay lit until the next round starts.
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end else if (is_result) begin
      player_win_light <= pscore >= dscore;
      dealer_win_light <= dscore >= pscore;
    end else if (state == IDLE && start) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) round_count <= '0;
    else if (clear_tally) round_count <= '0;
    else if (is_result) round_count <= round_count + 1'b1;
  sat_counter #(.W(TALLY_W)) u_player_wins (
    .clk(slow_clock), .rst(reset), .inc(is_result && pscore > dscore), .clr(clear_tally), .count(player_wins)
  );
  sat_counter #(.W(TALLY_W)) u_dealer_wins (
    .clk(slow_clock), .rst(reset), .inc(is_result && dscore > pscore), .clr(clear_tally), .count(dealer_wins)
  );
`ifdef BACCARAT_TIE_TALLY_EN
  sat_counter #(.W(TALLY_W)) u_ties (
    .clk(slow_clock), .rst(reset), .inc(is_result && pscore == dscore), .clr(clear_tally), .count(ties)
  );
`else
  assign ties = '0;
`endif
endmodule
